// File: rtl/sll_pkg.sv
// ============================================================================
// Module      : sll_pkg
// Description : Shared state encoding and widths for the iterative SLL unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sll_pkg;

    localparam int STAGE_W = 3;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sll_state_t;

endpackage

`default_nettype wire

// File: rtl/sll_stage.sv
// ============================================================================
// Module      : sll_stage
// Description : Combinational single stage: shift left by 2^stage when enabled
//               and flag any shifted-out bit that differs from the sign.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sll_stage
    import sll_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   i_value,
    input  logic [STAGE_W-1:0] i_stage,
    input  logic               i_enable,
    input  logic               i_sign,
    output logic [WIDTH-1:0]   o_value,
    output logic               o_overflow
);

    int w_shift;

    always_comb begin
        w_shift    = 32'(1) << i_stage;
        o_value    = i_value;
        o_overflow = 1'b0;
        if (i_enable) begin
            o_value = i_value << w_shift;
            // The top w_shift bits leave the word; each must equal the sign.
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= WIDTH - w_shift) begin
                    o_overflow = o_overflow | (i_value[i] ^ i_sign);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sll_iterative_unit.sv
// ============================================================================
// Module      : sll_iterative_unit
// Description : Multi-cycle shift-left-logical, one binary stage per clock,
//               start/ready handshake, signed-overflow flag.
//               Optional macro SLL_EARLY_EXIT_EN skips all-zero upper stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sll_iterative_unit
    import sll_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_start,
    input  logic [WIDTH-1:0]   data_input,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY,
    output logic               data_exception,
    output logic               ctrl_busy
);

    sll_state_t          r_state;
    sll_state_t          w_next;
    logic [WIDTH-1:0]    r_work;
    logic [SHAMT_W-1:0]  r_amt;
    logic                r_sign;
    logic                r_sticky;
    logic [STAGE_W-1:0]  r_stage;
    logic [WIDTH-1:0]    r_result;
    logic                r_exception;

    logic [WIDTH-1:0]    w_stage_val;
    logic                w_stage_ovf;
    logic                w_last;
    logic                w_accept;

    sll_stage #(.WIDTH(WIDTH)) u_stage (
        .i_value    (r_work),
        .i_stage    (r_stage),
        .i_enable   (r_amt[r_stage]),
        .i_sign     (r_sign),
        .o_value    (w_stage_val),
        .o_overflow (w_stage_ovf)
    );

`ifdef SLL_EARLY_EXIT_EN
    // Finish as soon as no higher amount bit remains to be applied.
    assign w_last = (r_stage == STAGE_W'(STAGES - 1)) ||
                    ((r_amt >> (r_stage + STAGE_W'(1))) == '0);
`else
    assign w_last = (r_stage == STAGE_W'(STAGES - 1));
`endif

    assign w_accept = ctrl_start && ((r_state == IDLE) || (r_state == DONE));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (ctrl_start) w_next = SHIFT;
            SHIFT:   if (w_last)     w_next = DONE;
            DONE:    w_next = ctrl_start ? SHIFT : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_work      <= '0;
            r_amt       <= '0;
            r_sign      <= 1'b0;
            r_sticky    <= 1'b0;
            r_stage     <= '0;
            r_result    <= '0;
            r_exception <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_work   <= data_input;
                r_amt    <= ctrl_shiftamt;
                r_sign   <= data_input[WIDTH-1];
                r_sticky <= 1'b0;
                r_stage  <= '0;
            end else if (r_state == SHIFT) begin
                r_work   <= w_stage_val;
                r_sticky <= r_sticky | w_stage_ovf;
                r_stage  <= r_stage + STAGE_W'(1);
                if (w_last) begin
                    r_result    <= w_stage_val;
                    r_exception <= r_sticky | w_stage_ovf |
                                   (w_stage_val[WIDTH-1] ^ r_sign);
                end
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exception;
    assign data_resultRDY = (r_state == DONE);
    assign ctrl_busy      = (r_state == SHIFT);

endmodule

`default_nettype wire

// File: tb/tb_sll_iterative_unit.sv
// ============================================================================
// Module      : tb_sll_iterative_unit
// Description : Scoreboard bench for sll_iterative_unit (honours SLL_EARLY_EXIT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sll_iterative_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_start;
    logic [31:0] data_input;
    logic [4:0]  ctrl_shiftamt;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        data_exception;
    logic        ctrl_busy;

    typedef struct {
        logic [31:0] result;
        logic        exc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    sll_iterative_unit #(.WIDTH(32), .STAGES(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_start     (ctrl_start),
        .data_input     (data_input),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception),
        .ctrl_busy      (ctrl_busy)
    );

    always #5 clock = ~clock;

    function automatic exp_t model(input logic [31:0] a, input logic [4:0] amt);
        exp_t   e;
        longint full;
        e.result = a << amt;
        full     = longint'($signed(a)) <<< amt;
        e.exc    = (full != longint'($signed(e.result)));
        return e;
    endfunction

    function automatic int exp_latency(input logic [4:0] amt);
`ifdef SLL_EARLY_EXIT_EN
        int hb = 0;
        for (int i = 0; i < 5; i++) if (amt[i]) hb = i;
        return hb + 1;
`else
        return 5;
`endif
    endfunction

    // Scoreboard: every RDY pulse consumes the oldest expectation.
    always @(negedge clock) begin
        if (data_resultRDY) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_rdy: got RDY=1 with result=%h, required no RDY", data_result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (data_result !== e.result) begin
                    errors = errors + 1;
                    $display("FAIL result: got %h, required %h", data_result, e.result);
                end
                checks = checks + 1;
                if (data_exception !== e.exc) begin
                    errors = errors + 1;
                    $display("FAIL exception: got %b, required %b (result %h)", data_exception, e.exc, e.result);
                end
            end
        end
    end

    // Issue one operation from idle and return the cycles until RDY (99 on timeout).
    task automatic run_op(input logic [31:0] a, input logic [4:0] amt, output int lat);
        @(negedge clock);
        data_input    = a;
        ctrl_shiftamt = amt;
        ctrl_start    = 1'b1;
        exp_q.push_back(model(a, amt));
        @(negedge clock);
        ctrl_start = 1'b0;
        data_input = $urandom;
        lat = 0;
        while (!data_resultRDY && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        if (lat >= 20) lat = 99;
    endtask

    task automatic test_reset;
        reset = 1'b1; ctrl_start = 1'b0; data_input = '0; ctrl_shiftamt = '0;
        repeat (3) @(negedge clock);
        checks++;
        if ({data_result, data_resultRDY, data_exception, ctrl_busy} !== 35'd0) begin
            errors++;
            $display("FAIL reset_state: got %h/%b/%b/%b, required all zero",
                     data_result, data_resultRDY, data_exception, ctrl_busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_op;
        int lat;
        @(negedge clock);
        data_input = 32'h0000FFFF; ctrl_shiftamt = 5'd8; ctrl_start = 1'b1;
        @(negedge clock);
        ctrl_start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if ({data_result, data_resultRDY, data_exception, ctrl_busy} !== 35'd0) begin
            errors++;
            $display("FAIL reset_mid_op: got %h/%b/%b/%b, required all zero",
                     data_result, data_resultRDY, data_exception, ctrl_busy);
        end
        repeat (8) @(negedge clock);
        run_op(32'h0000FFFF, 5'd8, lat);
        checks++;
        if (lat != exp_latency(5'd8)) begin
            errors++;
            $display("FAIL after_reset_latency: got %0d, required %0d", lat, exp_latency(5'd8));
        end
    endtask

    task automatic test_basic;
        int lat;
        run_op(32'h00000001, 5'd31, lat);
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL basic_latency: got %0d, required 5", lat);
        end
        @(negedge clock);
        checks++;
        if (data_resultRDY !== 1'b0) begin
            errors++;
            $display("FAIL rdy_one_cycle: got RDY=%b, required 0", data_resultRDY);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (data_result !== 32'h80000000 || data_exception !== 1'b1) begin
            errors++;
            $display("FAIL hold: got %h/%b, required 80000000/1", data_result, data_exception);
        end
    endtask

    task automatic test_negative;
        int lat;
        run_op(32'hFFFFFFFF, 5'd4, lat);
        checks++;
        if (lat != exp_latency(5'd4)) begin
            errors++;
            $display("FAIL neg_latency: got %0d, required %0d", lat, exp_latency(5'd4));
        end
        run_op(32'h12345678, 5'd0, lat);
        checks++;
        if (lat != exp_latency(5'd0)) begin
            errors++;
            $display("FAIL zero_amt_latency: got %0d, required %0d", lat, exp_latency(5'd0));
        end
    endtask

    task automatic test_overflow;
        int lat;
        run_op(32'h40000000, 5'd2, lat);
        run_op(32'h3FFFFFFF, 5'd1, lat);
        run_op(32'hC0000000, 5'd1, lat);
        run_op(32'hA0000000, 5'd1, lat);
        for (int i = 0; i < 6; i++) begin
            logic [4:0] amt;
            amt = 5'($urandom_range(0, 31));
            run_op($urandom, amt, lat);
            checks++;
            if (lat != exp_latency(amt)) begin
                errors++;
                $display("FAIL rand_latency: amt=%0d got %0d, required %0d", amt, lat, exp_latency(amt));
            end
        end
    endtask

    // Start held high with fresh operands each cycle; only accept edges count.
    task automatic test_back_to_back;
        repeat (3) @(negedge clock);
        for (int i = 0; i <= 18; i++) begin
            @(negedge clock);
            if (i > 0) begin
                checks++;
                if (data_resultRDY !== (i % 6 == 0)) begin
                    errors++;
                    $display("FAIL b2b_rdy: cycle %0d got RDY=%b, required %b", i, data_resultRDY, (i % 6 == 0));
                end
            end
            if (i < 18) begin
                data_input    = $urandom;
                ctrl_shiftamt = 5'(16 + $urandom_range(0, 15));
                ctrl_start    = 1'b1;
                if (i % 6 == 0) exp_q.push_back(model(data_input, ctrl_shiftamt));
            end else begin
                ctrl_start = 1'b0;
            end
        end
        repeat (8) @(negedge clock);
        checks++;
        if (ctrl_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got busy=%b, required 0", ctrl_busy);
        end
    endtask

`ifdef SLL_EARLY_EXIT_EN
    task automatic test_early_exit;
        int lat;
        run_op(32'h00000003, 5'b00010, lat);
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL early_lat2: got %0d, required 2", lat);
        end
        run_op(32'h00000003, 5'b10000, lat);
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL early_lat5: got %0d, required 5", lat);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_op();
        test_basic();
        test_negative();
        test_overflow();
        test_back_to_back();
`ifdef SLL_EARLY_EXIT_EN
        test_early_exit();
`endif
        repeat (10) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_rdy: got %0d outstanding results, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
